axi_rd_arbiter: RTL and testbench

Read-channel arbiter between the instruction-side and data-side read requesters and the single AXI AR/R channel pair of the core. It accepts burst read requests (cache line refills or uncached single-word reads) from both sides. It issues one AXI read at a time, tags it with a source ID, routes returning beats to the owner, and flags protocol errors. It sits inside the SRAM-to-AXI bridge; the write channels and the AR side-band tie-offs (lock/cache/prot) are handled elsewhere.

---
 rtl/axi_rd_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter: I-side and D-side burst reads onto one AXI AR/R pair, one burst in flight.
// Optional: define AXI_RD_ARB_RR_EN for round-robin arbitration (default: data over instruction).
module axi_rd_arbiter #(
  parameter logic [3:0] I_ARID = 4'd0,
  parameter logic [3:0] D_ARID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  // instruction-side requester
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  input  logic [7:0]  i_rd_len,
  input  logic [2:0]  i_rd_size,
  output logic        i_rd_gnt,
  output logic        i_rd_valid,
  output logic        i_rd_last,
  output logic        i_rd_err,
  // data-side requester
  input  logic        d_rd_req,
  input  logic [31:0] d_rd_addr,
  input  logic [7:0]  d_rd_len,
  input  logic [2:0]  d_rd_size,
  output logic        d_rd_gnt,
  output logic        d_rd_valid,
  output logic        d_rd_last,
  output logic        d_rd_err,
  // shared beat data and error flag
  output logic [31:0] rd_data,
  output logic        rd_proto_err,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;      // 1 = data side owns the current burst
  logic [3:0]  arid_q, arid_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        proto_err_q, proto_err_d;

  logic        pick_d;                // arbitration result: 1 = data side wins
  logic        beat_bad;

`ifdef AXI_RD_ARB_RR_EN
  logic        last_d_q, last_d_d;    // 1 = data side won the most recent grant

  always_comb begin
    pick_d = d_rd_req;
    if (d_rd_req && i_rd_req) begin
      pick_d = !last_d_q;
    end
  end

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == ADDR && arready) begin
      last_d_d = owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  always_comb begin
    pick_d = d_rd_req;
  end
`endif

  // A beat is malformed if its ID is foreign or rlast disagrees with the final-beat position.
  always_comb begin
    beat_bad = (rid != arid_q) || (rlast != (cnt_q == len_q));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      arid_q      <= 4'd0;
      addr_q      <= 32'd0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      cnt_q       <= 8'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      arid_q      <= arid_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    arid_d      = arid_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (i_rd_req || d_rd_req) begin
          state_d = ADDR;
          owner_d = pick_d;
          cnt_d   = 8'd0;
          if (pick_d) begin
            arid_d = D_ARID;
            addr_d = d_rd_addr;
            len_d  = d_rd_len;
            size_d = d_rd_size;
          end else begin
            arid_d = I_ARID;
            addr_d = i_rd_addr;
            len_d  = i_rd_len;
            size_d = i_rd_size;
          end
        end
      end
      ADDR: begin
        if (arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (rvalid) begin
          cnt_d = cnt_q + 8'd1;
          if (beat_bad) begin
            proto_err_d = 1'b1;
          end
          // Sequencing follows rlast only, even when the beat was malformed.
          if (rlast) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: AR side is state-derived, R side is a combinational pass-through gated by ownership.
  always_comb begin
    arvalid      = (state_q == ADDR);
    rready       = (state_q == DATA);
    arid         = arid_q;
    araddr       = addr_q;
    arlen        = len_q;
    arsize       = size_q;
    arburst      = 2'b01;
    rd_proto_err = proto_err_q;

    i_rd_gnt   = 1'b0;
    d_rd_gnt   = 1'b0;
    i_rd_valid = 1'b0;
    d_rd_valid = 1'b0;
    i_rd_last  = 1'b0;
    d_rd_last  = 1'b0;
    i_rd_err   = 1'b0;
    d_rd_err   = 1'b0;
    rd_data    = 32'd0;

    if (state_q == ADDR && arready) begin
      i_rd_gnt = !owner_q;
      d_rd_gnt = owner_q;
    end

    if (state_q == DATA && rvalid) begin
      rd_data    = rdata;
      i_rd_valid = !owner_q;
      d_rd_valid = owner_q;
      i_rd_last  = !owner_q && rlast;
      d_rd_last  = owner_q && rlast;
      i_rd_err   = !owner_q && (rresp != 2'b00);
      d_rd_err   = owner_q && (rresp != 2'b00);
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: bench-driven requesters and AXI slave, a transaction-level
// reference model compared every cycle, plus literal checks for the directed scenarios.
module tb_axi_rd_arbiter;

  localparam logic [3:0] I_ID = 4'd0;
  localparam logic [3:0] D_ID = 4'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_rd_req, d_rd_req;
  logic [31:0] i_rd_addr, d_rd_addr;
  logic [7:0]  i_rd_len, d_rd_len;
  logic [2:0]  i_rd_size, d_rd_size;
  logic        i_rd_gnt, i_rd_valid, i_rd_last, i_rd_err;
  logic        d_rd_gnt, d_rd_valid, d_rd_last, d_rd_err;
  logic [31:0] rd_data;
  logic        rd_proto_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.I_ARID(I_ID), .D_ARID(D_ID)) dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_len(i_rd_len), .i_rd_size(i_rd_size),
    .i_rd_gnt(i_rd_gnt), .i_rd_valid(i_rd_valid), .i_rd_last(i_rd_last), .i_rd_err(i_rd_err),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_len(d_rd_len), .d_rd_size(d_rd_size),
    .d_rd_gnt(d_rd_gnt), .d_rd_valid(d_rd_valid), .d_rd_last(d_rd_last), .d_rd_err(d_rd_err),
    .rd_data(rd_data), .rd_proto_err(rd_proto_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 60) $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // Slave knobs (written by the main sequence only)
  int   k_stall_pct = 0, k_gap_pct = 0, k_err_pct = 0, k_force_stall = 0, k_inj = 0;
  bit   k_resp_force = 0, k_pat_en = 0;
  logic [31:0] k_pat_base = 32'd0;

  // Transaction-level reference model
  bit          m_busy = 0, m_ar_done = 0, m_own = 0, m_perr = 0, m_last = 0;
  logic [31:0] m_addr = 0;
  logic [7:0]  m_len = 0;
  logic [2:0]  m_size = 0;
  int          m_beats = 0;

  // Observation logs (actual DUT behaviour, used by literal checks)
  int          gnt_cnt_i = 0, gnt_cnt_d = 0, n_beats_i = 0, n_beats_d = 0, n_err_d = 0;
  int          d_last_cyc = 0, gnt_cyc_d = 0;
  logic [31:0] last_data_i = 0;
  bit          arvalid_prev = 0;
  int          ar_rise_cyc[$];
  logic [3:0]  ar_rise_id[$];
  logic [31:0] ar_rise_addr[$];
  logic [7:0]  ar_rise_len[$];

  always @(negedge clk) begin : cmp
    bit av, rr, bt, win;
    logic [3:0] eid;
    if (cmp_en) begin
      av  = m_busy && !m_ar_done;
      rr  = m_busy && m_ar_done;
      bt  = rr && rvalid;
      eid = m_own ? D_ID : I_ID;
      chk("arvalid", arvalid, av);
      chk("rready", rready, rr);
      chk("arburst", arburst, 2'b01);
      if (av) begin
        chk("arid", arid, eid);
        chk("araddr", araddr, m_addr);
        chk("arlen", arlen, m_len);
        chk("arsize", arsize, m_size);
      end
      chk("i_gnt", i_rd_gnt, av && arready && !m_own);
      chk("d_gnt", d_rd_gnt, av && arready && m_own);
      chk("i_valid", i_rd_valid, bt && !m_own);
      chk("d_valid", d_rd_valid, bt && m_own);
      chk("i_last", i_rd_last, bt && rlast && !m_own);
      chk("d_last", d_rd_last, bt && rlast && m_own);
      chk("i_err", i_rd_err, bt && (rresp != 2'b00) && !m_own);
      chk("d_err", d_rd_err, bt && (rresp != 2'b00) && m_own);
      if (bt) chk("rd_data", rd_data, rdata);
      chk("proto_err", rd_proto_err, m_perr);

      if (i_rd_gnt) gnt_cnt_i++;
      if (d_rd_gnt) begin gnt_cnt_d++; gnt_cyc_d = cyc; end
      if (i_rd_gnt || d_rd_gnt)
        $display("TXN ar cyc=%0d side=%s id=%0d addr=%h len=%0d size=%0d", cyc,
                 d_rd_gnt ? "D" : "I", arid, araddr, arlen, arsize);
      if (arvalid && !arvalid_prev) begin
        ar_rise_cyc.push_back(cyc);
        ar_rise_id.push_back(arid);
        ar_rise_addr.push_back(araddr);
        ar_rise_len.push_back(arlen);
      end
      arvalid_prev = arvalid;
      if (i_rd_valid) begin
        n_beats_i++;
        if (i_rd_last) last_data_i = rd_data;
      end
      if (d_rd_valid) begin
        n_beats_d++;
        if (d_rd_err) n_err_d++;
        if (d_rd_last) d_last_cyc = cyc;
      end

      // advance model to the next cycle
      if (reset) begin
        m_busy = 0; m_ar_done = 0; m_perr = 0; m_last = 0;
      end else if (!m_busy) begin
        if (i_rd_req || d_rd_req) begin
`ifdef AXI_RD_ARB_RR_EN
          win = (i_rd_req && d_rd_req) ? !m_last : d_rd_req;
`else
          win = d_rd_req;
`endif
          m_busy = 1; m_ar_done = 0; m_own = win; m_beats = 0;
          m_addr = win ? d_rd_addr : i_rd_addr;
          m_len  = win ? d_rd_len  : i_rd_len;
          m_size = win ? d_rd_size : i_rd_size;
        end
      end else if (!m_ar_done) begin
        if (arready) begin m_ar_done = 1; m_last = m_own; end
      end else if (rvalid) begin
        if (rid != eid || rlast != (m_beats == int'(m_len))) m_perr = 1;
        m_beats++;
        if (rlast) m_busy = 0;
      end
    end
  end

  // AXI slave: one burst at a time, random stalls/gaps, optional fault injection
  bit          s_busy = 0, hs_will = 0, cons_will = 0, arv_seen = 0;
  int          s_beat = 0, s_last_at = 0, s_inj = 0, s_stall = 0;
  logic [3:0]  s_id = 0, cap_id = 0;
  logic [7:0]  cap_len = 0;

  always @(posedge clk) begin : slave
    #2;
    if (reset) begin
      s_busy = 0; hs_will = 0; cons_will = 0; arv_seen = 0;
      arready = 0; rvalid = 0; rlast = 0; rid = 0; rdata = 0; rresp = 0;
    end else begin
      if (hs_will) begin
        s_busy = 1; s_beat = 0; s_id = cap_id; s_inj = k_inj;
        s_last_at = int'(cap_len) + ((k_inj == 3) ? 1 : 0) - ((k_inj == 2) ? 1 : 0);
      end
      if (cons_will) begin
        if (rlast) s_busy = 0;
        s_beat++;
      end
      if (arvalid && !arv_seen) s_stall = k_force_stall;
      arv_seen = arvalid;
      if (arvalid && s_stall > 0) begin
        arready = 0;
        s_stall--;
      end else begin
        arready = ($urandom_range(99) >= k_stall_pct);
      end
      hs_will = arvalid && arready;
      cap_id  = arid;
      cap_len = arlen;
      if (s_busy && $urandom_range(99) >= k_gap_pct) begin
        rvalid = 1;
        rlast  = (s_beat == s_last_at);
        rid    = (s_inj == 1) ? 4'd5 : s_id;
        rdata  = k_pat_en ? (k_pat_base + 32'(s_beat)) : $urandom();
        rresp  = k_resp_force ? 2'b10 :
                 (($urandom_range(99) < k_err_pct) ? 2'($urandom_range(3, 1)) : 2'b00);
      end else begin
        rvalid = 0;
        rlast  = 1'($urandom_range(1));
        rid    = 4'($urandom_range(15));
        rdata  = $urandom();
        rresp  = 2'($urandom_range(3));
      end
      cons_will = rvalid && rready;
    end
  end

  task automatic req_side(input bit side_d, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s);
    int start;
    bit got;
    if (side_d) begin
      start = gnt_cnt_d; d_rd_req = 1; d_rd_addr = a; d_rd_len = l; d_rd_size = s;
    end else begin
      start = gnt_cnt_i; i_rd_req = 1; i_rd_addr = a; i_rd_len = l; i_rd_size = s;
    end
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk); #1;
      got = side_d ? (gnt_cnt_d != start) : (gnt_cnt_i != start);
    end
    if (side_d) d_rd_req = 0; else i_rd_req = 0;
    chk(side_d ? "gnt_wait_d" : "gnt_wait_i", got, 1'b1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk); #1;
      done = !m_busy && !i_rd_req && !d_rd_req;
    end
    chk("idle_wait", done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic rand_requester(input bit side_d, input int n);
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      req_side(side_d, $urandom(), 8'($urandom_range(7)), 3'($urandom_range(2)));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0, b0, bd0, g0, e0, r;
    bit ok;
    i_rd_req = 0; d_rd_req = 0;
    i_rd_addr = 0; d_rd_addr = 0; i_rd_len = 0; d_rd_len = 0; i_rd_size = 0; d_rd_size = 0;
    @(posedge clk); #1;
    cmp_en = 1;
    @(posedge clk); #3;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_arid", arid, 4'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arlen", arlen, 8'd0);
    chk("rst_arsize", arsize, 3'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_proto", rd_proto_err, 1'b0);
    @(posedge clk); #1;
    reset = 0;

    // Instruction line refill
    k_pat_en = 1; k_pat_base = 32'hA0;
    n0 = ar_rise_cyc.size(); b0 = n_beats_i; bd0 = n_beats_d; g0 = gnt_cnt_d;
    r = cyc;
    req_side(0, 32'h1FC0_0010, 8'd3, 3'd2);
    wait_idle();
    chk("t1_ar_seen", ar_rise_cyc.size(), n0 + 1);
    if (ar_rise_cyc.size() > n0) begin
      chk("t1_arvalid_lat", ar_rise_cyc[n0], r + 1);
      chk("t1_arid", ar_rise_id[n0], 4'd0);
      chk("t1_arlen", ar_rise_len[n0], 8'd3);
      chk("t1_araddr", ar_rise_addr[n0], 32'h1FC0_0010);
    end
    chk("t1_beats", n_beats_i - b0, 4);
    chk("t1_last_data", last_data_i, 32'hA3);
    chk("t1_d_silent", (n_beats_d - bd0) + (gnt_cnt_d - g0), 0);
    k_pat_en = 0;

    // Simultaneous requests
    n0 = ar_rise_cyc.size();
    fork
      req_side(1, 32'h8000_0100, 8'd0, 3'd2);
      req_side(0, 32'h1FC0_0000, 8'd0, 3'd2);
    join
    wait_idle();
    ok = ar_rise_cyc.size() >= n0 + 2;
    chk("t2_ar_seen", ok, 1'b1);
    if (ok) begin
      chk("t2_first_id", ar_rise_id[n0], 4'd1);
      chk("t2_first_addr", ar_rise_addr[n0], 32'h8000_0100);
      chk("t2_second_id", ar_rise_id[n0 + 1], 4'd0);
      chk("t2_b2b", ar_rise_cyc[n0 + 1] - d_last_cyc, 2);
    end

    // Data alone, then a simultaneous pair: round-robin favours instruction here
    req_side(1, 32'h8000_0200, 8'd1, 3'd2);
    wait_idle();
    n0 = ar_rise_cyc.size();
    fork
      req_side(1, 32'h8000_0300, 8'd0, 3'd2);
      req_side(0, 32'h1FC0_0040, 8'd0, 3'd2);
    join
    wait_idle();
    ok = ar_rise_cyc.size() >= n0 + 2;
    chk("t2b_ar_seen", ok, 1'b1);
    if (ok) begin
`ifdef AXI_RD_ARB_RR_EN
      chk("t2b_first_id", ar_rise_id[n0], 4'd0);
`else
      chk("t2b_first_id", ar_rise_id[n0], 4'd1);
`endif
    end

    // AR stall of 5 cycles plus R gaps
    k_force_stall = 5; k_gap_pct = 50;
    n0 = ar_rise_cyc.size(); bd0 = n_beats_d;
    req_side(1, 32'h8000_1000, 8'd3, 3'd2);
    wait_idle();
    if (ar_rise_cyc.size() > n0) chk("t3_gnt_delay", gnt_cyc_d - ar_rise_cyc[n0], 5);
    else chk("t3_ar_seen", ar_rise_cyc.size(), n0 + 1);
    chk("t3_beats", n_beats_d - bd0, 4);
    k_force_stall = 0; k_gap_pct = 0;

    // SLVERR response
    k_resp_force = 1;
    e0 = n_err_d; bd0 = n_beats_d;
    req_side(1, 32'h8000_2000, 8'd0, 3'd2);
    wait_idle();
    chk("t4_err", n_err_d - e0, 1);
    chk("t4_beats", n_beats_d - bd0, 1);
    chk("t4_proto", rd_proto_err, 1'b0);
    k_resp_force = 0;

    // Early rlast
    k_inj = 2;
    req_side(0, 32'h1FC0_0100, 8'd3, 3'd2);
    wait_idle();
    k_inj = 0;
    chk("t5_proto_set", rd_proto_err, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    chk("t5_proto_sticky", rd_proto_err, 1'b1);
    pulse_reset();
    #2 chk("t5_proto_clr", rd_proto_err, 1'b0);
    @(posedge clk); #1;

    // Foreign rid
    k_inj = 1;
    req_side(1, 32'h8000_3000, 8'd1, 3'd2);
    wait_idle();
    k_inj = 0;
    chk("t5b_proto_set", rd_proto_err, 1'b1);
    pulse_reset();

    // Reset in DATA after two beats
    b0 = n_beats_i;
    req_side(0, 32'h1FC0_0200, 8'd3, 3'd2);
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      ok = (n_beats_i - b0) >= 2;
      if (!ok) begin @(posedge clk); #1; end
    end
    chk("t6_two_beats", ok, 1'b1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    #2;
    chk("t6_rready", rready, 1'b0);
    chk("t6_arvalid", arvalid, 1'b0);
    chk("t6_i_valid", i_rd_valid, 1'b0);
    chk("t6_araddr", araddr, 32'd0);
    chk("t6_arlen", arlen, 8'd0);
    chk("t6_rd_data", rd_data, 32'd0);
    chk("t6_beats_cut", n_beats_i - b0, 2);
    @(posedge clk); #1;
    bd0 = n_beats_d;
    req_side(1, 32'h8000_4000, 8'd1, 3'd2);
    wait_idle();
    chk("t6_fresh_beats", n_beats_d - bd0, 2);

    // Randomized traffic from both sides
    k_stall_pct = 30; k_gap_pct = 30; k_err_pct = 20;
    fork
      rand_requester(0, 25);
      rand_requester(1, 25);
    join
    wait_idle();
    chk("rand_proto_clean", rd_proto_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
